// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake and status bundle for sync_fifo.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
);
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             wfull;
  logic             awfull;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             arempty;
  logic [ASIZE:0]   level;
  logic             overflow;
  logic             underflow;

  modport master (
    output winc, wdata, rinc,
    input  wfull, awfull, rdata, rempty, arempty, level, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output wfull, awfull, rdata, rempty, arempty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy level, almost-full/almost-empty
// flags and sticky overflow/underflow errors.
// Optional macro SYNC_FIFO_FWFT_EN: when defined, rdata is first-word-fall-
// through (head word presented while not empty); otherwise rdata is loaded
// on each accepted read.
module sync_fifo #(
  parameter int DSIZE   = 32,
  parameter int ASIZE   = 4,
  parameter int AWFULL  = 2**ASIZE-2,
  parameter int AREMPTY = 1
) (
  input  logic       clk,
  input  logic       rst,
  sync_fifo_if.slave bus
);
  localparam int DEPTH = 2**ASIZE;
  localparam logic [ASIZE:0] DEPTH_LV   = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AWFULL_LV  = (ASIZE+1)'(AWFULL);
  localparam logic [ASIZE:0] AREMPTY_LV = (ASIZE+1)'(AREMPTY);
  localparam logic [ASIZE:0] ONE_LV     = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0]   wptr_reg, wptr_next;
  logic [ASIZE:0]   rptr_reg, rptr_next;
  logic [ASIZE:0]   level_reg, level_next;
  logic             wfull_reg, awfull_reg, rempty_reg, arempty_reg;
  logic             overflow_reg, underflow_reg;
  logic [DSIZE-1:0] rdata_reg;
  logic             wr_ok, rd_ok;

  // Accept decisions look only at registered flags, so nothing combinational
  // reaches the outputs from winc/rinc.
  always_comb begin
    wr_ok      = bus.winc & ~wfull_reg;
    rd_ok      = bus.rinc & ~rempty_reg;
    wptr_next  = wr_ok ? (wptr_reg + ONE_LV) : wptr_reg;
    rptr_next  = rd_ok ? (rptr_reg + ONE_LV) : rptr_reg;
    level_next = level_reg;
    if (wr_ok && !rd_ok)
      level_next = level_reg + ONE_LV;
    else if (!wr_ok && rd_ok)
      level_next = level_reg - ONE_LV;
  end

  // Storage array write; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wptr_reg[ASIZE-1:0]] <= bus.wdata;
  end

  // Pointers, level, status flags (from next level) and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      level_reg     <= '0;
      wfull_reg     <= 1'b0;
      awfull_reg    <= 1'b0;
      rempty_reg    <= 1'b1;
      arempty_reg   <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      level_reg     <= level_next;
      wfull_reg     <= (level_next == DEPTH_LV);
      awfull_reg    <= (level_next >= AWFULL_LV);
      rempty_reg    <= (level_next == '0);
      arempty_reg   <= (level_next <= AREMPTY_LV);
      overflow_reg  <= overflow_reg | (bus.winc & wfull_reg);
      underflow_reg <= underflow_reg | (bus.rinc & rempty_reg);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic [DSIZE-1:0] head_next;

  // Head word after this edge: the word being written now if it becomes
  // the head (write into empty, or the last word popped while writing).
  always_comb begin
    head_next = mem[rptr_next[ASIZE-1:0]];
    if (wr_ok && (wptr_reg == rptr_next))
      head_next = bus.wdata;
  end

  // Present the head whenever the FIFO will be non-empty; hold while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_reg <= '0;
    else if (level_next != '0)
      rdata_reg <= head_next;
  end
`else
  // Registered read: load the head word on each accepted read only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_reg <= '0;
    else if (rd_ok)
      rdata_reg <= mem[rptr_reg[ASIZE-1:0]];
  end
`endif

  assign bus.wfull     = wfull_reg;
  assign bus.awfull    = awfull_reg;
  assign bus.rempty    = rempty_reg;
  assign bus.arempty   = arempty_reg;
  assign bus.level     = level_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
  assign bus.rdata     = rdata_reg;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo (ASIZE=4, AWFULL=14, AREMPTY=1).
// Works in both read-port modes (SYNC_FIFO_FWFT_EN defined or not).
module tb_sync_fifo;
  logic clk;
  logic rst;

  sync_fifo_if #(.DSIZE(32), .ASIZE(4)) bus ();

  sync_fifo #(.DSIZE(32), .ASIZE(4), .AWFULL(14), .AREMPTY(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [31:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Write one word; model accepts it only if not full.
  task automatic push_word(input logic [31:0] d);
    bus.winc  = 1'b1;
    bus.wdata = d;
    if (sb.size() < 16) sb.push_back(d);
    cyc();
    bus.winc = 1'b0;
  endtask

  // Read one word and return what the read port showed for it.
  task automatic pop_word(output logic [31:0] got);
`ifdef SYNC_FIFO_FWFT_EN
    got = bus.rdata;
    bus.rinc = 1'b1;
    cyc();
    bus.rinc = 1'b0;
`else
    bus.rinc = 1'b1;
    cyc();
    bus.rinc = 1'b0;
    got = bus.rdata;
`endif
  endtask

  // Simultaneous write+read; model decides acceptance from pre-edge state.
  task automatic both_word(input logic [31:0] d, output logic [31:0] got,
                           output logic [31:0] exp, output bit rd);
    bit wr;
    wr = (sb.size() < 16);
    rd = (sb.size() > 0);
    exp = '0;
    if (rd) exp = sb.pop_front();
    if (wr) sb.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    got = bus.rdata;
`endif
    bus.winc = 1'b1; bus.rinc = 1'b1; bus.wdata = d;
    cyc();
    bus.winc = 1'b0; bus.rinc = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    got = bus.rdata;
`endif
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    sb.delete();
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) cyc();
    rst = 1'b0;
    cyc();
    n_cmp++; if (bus.rempty !== 1'b1) begin n_err++; $display("FAIL reset_rempty got=%b exp=1", bus.rempty); end
    n_cmp++; if (bus.arempty !== 1'b1) begin n_err++; $display("FAIL reset_arempty got=%b exp=1", bus.arempty); end
    n_cmp++; if (bus.wfull !== 1'b0) begin n_err++; $display("FAIL reset_wfull got=%b exp=0", bus.wfull); end
    n_cmp++; if (bus.awfull !== 1'b0) begin n_err++; $display("FAIL reset_awfull got=%b exp=0", bus.awfull); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
    n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL reset_underflow got=%b exp=0", bus.underflow); end
    n_cmp++; if (bus.rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
    $display("reset: level=%0d rempty=%b", bus.level, bus.rempty);
  endtask

  task automatic test_single();
    logic [31:0] got, exp;
    push_word(32'hA);
    n_cmp++; if (bus.level !== 5'd1) begin n_err++; $display("FAIL single_level1 got=%0d exp=1", bus.level); end
    n_cmp++; if (bus.rempty !== 1'b0) begin n_err++; $display("FAIL single_rempty got=%b exp=0", bus.rempty); end
`ifdef SYNC_FIFO_FWFT_EN
    n_cmp++; if (bus.rdata !== 32'hA) begin n_err++; $display("FAIL single_fwft_rdata got=%h exp=a", bus.rdata); end
`endif
    exp = sb.pop_front();
    pop_word(got);
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL single_data got=%h exp=%h", got, exp); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL single_level0 got=%0d exp=0", bus.level); end
    $display("single: wrote a read %h level=%0d", got, bus.level);
  endtask

  task automatic test_fill();
    logic [4:0] el;
    for (int i = 0; i < 16; i++) begin
      push_word(32'(i));
      el = 5'(sb.size());
      n_cmp++; if (bus.level !== el) begin n_err++; $display("FAIL fill_level got=%0d exp=%0d", bus.level, el); end
      n_cmp++; if (bus.awfull !== (el >= 5'd14)) begin n_err++; $display("FAIL fill_awfull lvl=%0d got=%b", el, bus.awfull); end
      n_cmp++; if (bus.wfull !== (el == 5'd16)) begin n_err++; $display("FAIL fill_wfull lvl=%0d got=%b", el, bus.wfull); end
      n_cmp++; if (bus.arempty !== (el <= 5'd1)) begin n_err++; $display("FAIL fill_arempty lvl=%0d got=%b", el, bus.arempty); end
      $display("fill: write %0d level=%0d awfull=%b wfull=%b arempty=%b", i, bus.level, bus.awfull, bus.wfull, bus.arempty);
    end
    push_word(32'hDEAD);
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow); end
    n_cmp++; if (bus.level !== 5'd16) begin n_err++; $display("FAIL fill_level_after_ovf got=%0d exp=16", bus.level); end
    $display("fill: 17th write overflow=%b level=%0d", bus.overflow, bus.level);
  endtask

  task automatic test_drain_wrap();
    logic [31:0] got, exp;
    for (int i = 0; i < 16; i++) begin
      exp = sb.pop_front();
      pop_word(got);
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL drain_data got=%h exp=%h", got, exp); end
      n_cmp++; if (bus.rempty !== (sb.size() == 0)) begin n_err++; $display("FAIL drain_rempty lvl=%0d got=%b", sb.size(), bus.rempty); end
      $display("drain: read %h level=%0d", got, bus.level);
    end
    pop_word(got);
    n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL drain_underflow got=%b exp=1", bus.underflow); end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL drain_level_after_udf got=%0d exp=0", bus.level); end
    n_cmp++; if (bus.rdata !== 32'd15) begin n_err++; $display("FAIL drain_rdata_hold got=%h exp=f", bus.rdata); end
    $display("drain: extra read underflow=%b rdata=%h", bus.underflow, bus.rdata);
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 5; k++) push_word(32'h100 + 32'(r * 5 + k));
      for (int k = 0; k < 5; k++) begin
        exp = sb.pop_front();
        pop_word(got);
        n_cmp++; if (got !== exp) begin n_err++; $display("FAIL wrap_data got=%h exp=%h", got, exp); end
        $display("wrap: read %h", got);
      end
    end
  endtask

  task automatic test_simul();
    logic [31:0] got, exp;
    bit rd;
    pulse_reset();
    for (int i = 0; i < 16; i++) push_word(32'h200 + 32'(i));
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL simul_pre_overflow got=%b exp=0", bus.overflow); end
    both_word(32'h2FF, got, exp, rd);
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL simul_full_data got=%h exp=%h", got, exp); end
    n_cmp++; if (bus.level !== 5'd15) begin n_err++; $display("FAIL simul_full_level got=%0d exp=15", bus.level); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL simul_full_overflow got=%b exp=1", bus.overflow); end
    $display("simul: full w+r read %h level=%0d overflow=%b", got, bus.level, bus.overflow);
    for (int i = 0; i < 7; i++) begin
      exp = sb.pop_front();
      pop_word(got);
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL simul_pop_data got=%h exp=%h", got, exp); end
    end
    for (int k = 0; k < 4; k++) begin
      both_word(32'h300 + 32'(k), got, exp, rd);
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL simul_mid_data got=%h exp=%h", got, exp); end
      n_cmp++; if (bus.level !== 5'd8) begin n_err++; $display("FAIL simul_mid_level got=%0d exp=8", bus.level); end
      $display("simul: mid w+r read %h level=%0d", got, bus.level);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_word(got);
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL simul_drain_data got=%h exp=%h", got, exp); end
    end
    both_word(32'h400, got, exp, rd);
    n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL simul_empty_underflow got=%b exp=1", bus.underflow); end
    n_cmp++; if (bus.level !== 5'd1) begin n_err++; $display("FAIL simul_empty_level got=%0d exp=1", bus.level); end
    exp = sb.pop_front();
    pop_word(got);
    n_cmp++; if (got !== exp) begin n_err++; $display("FAIL simul_empty_data got=%h exp=%h", got, exp); end
    $display("simul: empty w+r then read %h", got);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    pulse_reset();
    pop_word(got);
    n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_underflow got=%b exp=1", bus.underflow); end
    for (int i = 0; i < 7; i++) push_word(32'h500 + 32'(i));
    n_cmp++; if (bus.level !== 5'd7) begin n_err++; $display("FAIL rstmid_level7 got=%0d exp=7", bus.level); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL rstmid_level got=%0d exp=0", bus.level); end
    n_cmp++; if (bus.rempty !== 1'b1) begin n_err++; $display("FAIL rstmid_rempty got=%b exp=1", bus.rempty); end
    n_cmp++; if (bus.underflow !== 1'b0) begin n_err++; $display("FAIL rstmid_underflow got=%b exp=0", bus.underflow); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got=%b exp=0", bus.overflow); end
    $display("rstmid: async reset level=%0d rempty=%b", bus.level, bus.rempty);
    repeat (2) cyc();
    rst = 1'b0;
    sb.delete();
    cyc();
    for (int i = 0; i < 3; i++) push_word(32'h600 + 32'(i));
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      pop_word(got);
      n_cmp++; if (got !== exp) begin n_err++; $display("FAIL rstmid_data got=%h exp=%h", got, exp); end
      $display("rstmid: read %h", got);
    end
    n_cmp++; if (bus.level !== 5'd0) begin n_err++; $display("FAIL rstmid_final_level got=%0d exp=0", bus.level); end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.winc = 1'b0;
    bus.rinc = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_single();
    test_fill();
    test_drain_wrap();
    test_simul();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
